// File: rtl/eth_phy_10g_pkg.sv
// eth_phy_10g_pkg: shared sync-header codes, idle payload, descrambler taps, BER FSM states
package eth_phy_10g_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [63:0] IDLE_DATA = 64'h0707070707070707;
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  typedef enum logic [1:0] {BER_IDLE, BER_COUNT, BER_HI} ber_state_t;
  function automatic logic hdr_valid(input logic [1:0] h);
    return h == SYNC_DATA || h == SYNC_CTRL;
  endfunction
endpackage

// File: rtl/eth_phy_10g_ber_mon.sv
// eth_phy_10g_ber_mon: BER monitor (clk, rst, lock, hdr in; high_ber out), counts invalid headers per timer window
module eth_phy_10g_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int BER_TIMER_CYCLES = 19531,
  parameter int BER_THRESHOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  input  logic [1:0] hdr,
  output logic       high_ber
);
  localparam int TW = $clog2(BER_TIMER_CYCLES);
  ber_state_t state;
  logic [TW-1:0] timer;
  logic [4:0] cnt, cnt_nxt;
  logic expiry, hit;
  always_comb begin
    cnt_nxt = (!hdr_valid(hdr) && cnt != 5'(BER_THRESHOLD)) ? cnt + 5'd1 : cnt;
    expiry = timer == TW'(BER_TIMER_CYCLES - 1);
    hit = cnt_nxt == 5'(BER_THRESHOLD);
  end
  always_ff @(posedge clk) begin
    if (rst || !lock) begin
      state <= BER_IDLE;
      timer <= '0;
      cnt <= '0;
      high_ber <= 1'b0;
    end else if (state == BER_IDLE) begin
      state <= BER_COUNT;
    end else begin
      timer <= expiry ? '0 : timer + 1'b1;
      cnt <= expiry ? '0 : cnt_nxt;
      if (hit) begin
        high_ber <= 1'b1;
        state <= BER_HI;
      end else if (expiry) begin
        high_ber <= 1'b0;
        state <= BER_COUNT;
      end
    end
  end
endmodule

// File: rtl/eth_phy_10g_rx_descrambler.sv
// eth_phy_10g_rx_descrambler: x^58+x^39+1 payload descrambler (clk, i_rst, lock/hdr/data in; registered hdr/data/lock/high_ber out), BER monitor under ETH_PHY_RX_BER_MON_EN
module eth_phy_10g_rx_descrambler
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH = 2,
  parameter int BER_TIMER_CYCLES = 19531,
  parameter int BER_THRESHOLD = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_rx_block_lock,
  input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr,
  input  logic [DATA_WIDTH-1:0] i_serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  o_rx_hdr,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_block_lock,
  output logic                  o_rx_high_ber
);
  logic [SCR_TAP_B-1:0] scr;
  logic [DATA_WIDTH+SCR_TAP_B-1:0] ext;
  logic [DATA_WIDTH-1:0] out;
  always_comb begin
    ext = {i_serdes_rx_data, scr};
    out = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      out[i] = ext[i+SCR_TAP_B] ^ ext[i+SCR_TAP_B-SCR_TAP_A] ^ ext[i];
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      scr <= '0;
      o_rx_hdr <= '0;
      o_rx_data <= IDLE_DATA;
      o_rx_block_lock <= 1'b0;
    end else begin
      scr <= i_serdes_rx_data[DATA_WIDTH-1:DATA_WIDTH-SCR_TAP_B];
      o_rx_hdr <= i_rx_block_lock ? i_serdes_rx_hdr : '0;
      o_rx_data <= i_rx_block_lock ? out : IDLE_DATA;
      o_rx_block_lock <= i_rx_block_lock;
    end
  end
`ifdef ETH_PHY_RX_BER_MON_EN
  eth_phy_10g_ber_mon #(
    .BER_TIMER_CYCLES(BER_TIMER_CYCLES),
    .BER_THRESHOLD(BER_THRESHOLD)
  ) u_ber_mon (
    .clk(clk),
    .rst(i_rst),
    .lock(i_rx_block_lock),
    .hdr(i_serdes_rx_hdr),
    .high_ber(o_rx_high_ber)
  );
`else
  assign o_rx_high_ber = 1'b0;
`endif
endmodule
